full_adder: RTL and testbench

- Parameterised, registered ripple-carry adder/subtractor built from per-bit full-adder cells (sum = a^b^c, carry = majority(a,b,c)).
- One operation per clock. Results and flags are registered, with 1-cycle latency.
- Used as the arithmetic leaf of the combinational/arithmetic library.
- Subtraction XORs operand B with the mode bit and feeds the adjusted carry-in into bit 0.

---
 rtl/full_adder_if.sv | 26 ++
 rtl/full_adder.sv | 76 +++++++
 tb/tb_full_adder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/full_adder_if.sv
// Operand/result bundle for the registered ripple-carry adder/subtractor.
// The master drives operands and control; the slave (the adder) returns registered results.
interface full_adder_if #(
    parameter int WIDTH = 4
);
    logic             valid_in;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             mode;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             zero;
    logic             valid_out;

    modport master (
        output valid_in, a, b, cin, mode,
        input  sum, cout, overflow, zero, valid_out
    );

    modport slave (
        input  valid_in, a, b, cin, mode,
        output sum, cout, overflow, zero, valid_out
    );
endinterface

// File: rtl/full_adder.sv
// Registered ripple-carry adder/subtractor built from per-bit full-adder cells.
// mode=1 inverts B and the carry-in, so cin acts as a borrow-in; results appear one cycle later.
module full_adder #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    full_adder_if.slave  bus
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_raw;
    logic             ovf_raw;
    logic             zero_raw;

    logic [WIDTH-1:0] sum_d,       sum_q;
    logic             cout_d,      cout_q;
    logic             overflow_d,  overflow_q;
    logic             zero_d,      zero_q;
    logic             valid_out_d, valid_out_q;

    // Borrow-in convention: c[0] = cin ^ mode, so mode=1,cin=0 gives A + ~B + 1 = A - B.
    assign carry[0] = bus.cin ^ bus.mode;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            assign b_eff[gi]     = bus.b[gi] ^ bus.mode;
            assign sum_raw[gi]   = bus.a[gi] ^ b_eff[gi] ^ carry[gi];
            assign carry[gi + 1] = (bus.a[gi] & b_eff[gi])
                                 | (bus.a[gi] & carry[gi])
                                 | (b_eff[gi] & carry[gi]);
        end
    endgenerate

    // Signed overflow: carry into the MSB differs from carry out of it.
    assign ovf_raw  = carry[WIDTH] ^ carry[WIDTH-1];
    assign zero_raw = (sum_raw == '0);

    always_comb begin
        sum_d       = sum_q;
        cout_d      = cout_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        valid_out_d = bus.valid_in;
        if (bus.valid_in) begin
            sum_d      = sum_raw;
            cout_d     = carry[WIDTH];
            overflow_d = ovf_raw;
            zero_d     = zero_raw;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            valid_out_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;
    assign bus.valid_out = valid_out_q;

endmodule

// File: tb/tb_full_adder.sv
// Directed self-checking bench for the 4-bit registered adder/subtractor.
module tb_full_adder;

    logic clk = 1'b0;
    logic rst_n;
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;

    full_adder_if #(.WIDTH(4)) fa_bus ();

    full_adder #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fa_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks every output against hand-computed values.
    task automatic chk_all(input string tag, input logic [3:0] s, input logic co,
                           input logic ov, input logic z, input logic v);
        chk({tag, ".sum"},       {28'd0, fa_bus.sum}, {28'd0, s});
        chk({tag, ".cout"},      {31'd0, fa_bus.cout}, {31'd0, co});
        chk({tag, ".overflow"},  {31'd0, fa_bus.overflow}, {31'd0, ov});
        chk({tag, ".zero"},      {31'd0, fa_bus.zero}, {31'd0, z});
        chk({tag, ".valid_out"}, {31'd0, fa_bus.valid_out}, {31'd0, v});
        $display("txn %s: sum=%b cout=%b ovf=%b zero=%b valid=%b", tag,
                 fa_bus.sum, fa_bus.cout, fa_bus.overflow, fa_bus.zero, fa_bus.valid_out);
    endtask

    task automatic set_op(input logic [3:0] ta, input logic [3:0] tb, input logic tc, input logic tm);
        fa_bus.valid_in = 1'b1;
        fa_bus.a        = ta;
        fa_bus.b        = tb;
        fa_bus.cin      = tc;
        fa_bus.mode     = tm;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n           = 1'b1;
        fa_bus.valid_in = 1'b0;
        fa_bus.a        = 4'd0;
        fa_bus.b        = 4'd0;
        fa_bus.cin      = 1'b0;
        fa_bus.mode     = 1'b0;

        // Load a nonzero result, then assert reset mid-cycle and check before any edge.
        step();
        set_op(4'b0111, 4'b0000, 1'b1, 1'b0);
        step();
        fa_bus.valid_in = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        set_op(4'b0101, 4'b0011, 1'b0, 1'b0);
        step();
        chk_all("reset_hold", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        fa_bus.valid_in = 1'b0;
        step();
        step();
        chk_all("idle_after_reset", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

        set_op(4'b0101, 4'b0011, 1'b0, 1'b0); step();
        chk_all("add_5p3", 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1);
        set_op(4'b0101, 4'b0011, 1'b0, 1'b1); step();
        chk_all("sub_5m3", 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1);
        set_op(4'b1000, 4'b0010, 1'b0, 1'b0); step();
        chk_all("add_8p2", 4'b1010, 1'b0, 1'b0, 1'b0, 1'b1);
        set_op(4'b1000, 4'b0010, 1'b0, 1'b1); step();
        chk_all("sub_8m2", 4'b0110, 1'b1, 1'b1, 1'b0, 1'b1);
        set_op(4'b0011, 4'b0101, 1'b0, 1'b1); step();
        chk_all("sub_3m5", 4'b1110, 1'b0, 1'b0, 1'b0, 1'b1);
        set_op(4'b0110, 4'b0110, 1'b0, 1'b1); step();
        chk_all("sub_6m6", 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1);
        set_op(4'b1111, 4'b0001, 1'b0, 1'b0); step();
        chk_all("add_15p1", 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1);
        set_op(4'b0111, 4'b0000, 1'b1, 1'b0); step();
        chk_all("add_7p0c1", 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1);
        set_op(4'b0100, 4'b0001, 1'b1, 1'b1); step();
        chk_all("sub_4m1b1", 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1);

        // Drop valid: valid_out falls, result registers hold.
        fa_bus.valid_in = 1'b0;
        fa_bus.a = 4'b1111; fa_bus.b = 4'b1111;
        step();
        chk_all("hold_1", 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("hold_2", 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);

        // Back-to-back stream: one result per cycle.
        set_op(4'b0001, 4'b0010, 1'b0, 1'b0); step();
        chk_all("stream_1", 4'b0011, 1'b0, 1'b0, 1'b0, 1'b1);
        set_op(4'b1001, 4'b0111, 1'b0, 1'b0); step();
        chk_all("stream_2", 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1);
        set_op(4'b0000, 4'b0001, 1'b0, 1'b1); step();
        chk_all("stream_3", 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1);
        set_op(4'b1000, 4'b0001, 1'b0, 1'b1); step();
        chk_all("stream_4", 4'b0111, 1'b1, 1'b1, 1'b0, 1'b1);

        // Reset during the stream: in-flight result discarded.
        set_op(4'b0101, 4'b0101, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("stream_reset", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("stream_reset_edge", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        fa_bus.valid_in = 1'b0;
        step();
        chk_all("post_release_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        set_op(4'b0010, 4'b0011, 1'b0, 1'b0); step();
        chk_all("post_release_op", 4'b0101, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
